// File: rtl/pn_pkg.sv
// Shared types and default polynomial constants for the PN word generator.
package pn_pkg;

  typedef enum logic [0:0] {StFill, StPresent} pn_state_e;

  localparam logic [3:0]  TapsW4  = 4'hC;
  localparam logic [6:0]  TapsW7  = 7'h60;
  localparam logic [7:0]  TapsW8  = 8'h9C;
  localparam logic [14:0] TapsW15 = 15'h6000;

  localparam logic [3:0]  SeedW4  = 4'h1;
  localparam logic [6:0]  SeedW7  = 7'h01;
  localparam logic [7:0]  SeedW8  = 8'h01;
  localparam logic [14:0] SeedW15 = 15'h0001;

  // Unlisted widths fall back to the two top bits, which at least never yields a null mask.
  function automatic logic [31:0] default_taps(int unsigned width);
    unique case (width)
      4:       return 32'(TapsW4);
      7:       return 32'(TapsW7);
      8:       return 32'(TapsW8);
      15:      return 32'(TapsW15);
      default: return (32'd3 << (width - 2));
    endcase
  endfunction

endpackage

// File: rtl/pn_lfsr_core.sv
// Fibonacci LFSR register with runtime-loadable seed and feedback mask.
module pn_lfsr_core #(
  parameter int unsigned       LFSR_W       = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_TAPS = LFSR_W'(pn_pkg::default_taps(LFSR_W)),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(1)
) (
  input  logic              clk_o,
  input  logic              reset_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [LFSR_W-1:0] taps_in,
  output logic              pn_bit,
  output logic              seed_hit,
  output logic              lockup
);

  logic [LFSR_W-1:0] state_q, state_d;
  logic [LFSR_W-1:0] taps_q, taps_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [LFSR_W-1:0] step_val;
  logic              lockup_q, lockup_d;
  logic              seed_zero;

  assign step_val  = {state_q[LFSR_W-2:0], ^(state_q & taps_q)};
  assign seed_zero = (seed_in == '0);

  always_comb begin
    state_d  = state_q;
    taps_d   = taps_q;
    seed_d   = seed_q;
    lockup_d = lockup_q;
    if (load) begin
      // An all-zero seed would lock the register, so substitute the default and flag it.
      state_d  = seed_zero ? DEFAULT_SEED : seed_in;
      seed_d   = seed_zero ? DEFAULT_SEED : seed_in;
      taps_d   = taps_in;
      lockup_d = seed_zero;
    end else if (step) begin
      state_d = step_val;
    end
  end

  always_ff @(posedge clk_o or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= DEFAULT_SEED;
      taps_q   <= DEFAULT_TAPS;
      seed_q   <= DEFAULT_SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      seed_q   <= seed_d;
      lockup_q <= lockup_d;
    end
  end

  assign pn_bit   = state_q[0];
  assign seed_hit = (step_val == seed_q);
  assign lockup   = lockup_q;

endmodule

// File: rtl/pn_gen_param.sv
// PN generator packing the serial LFSR stream into OUT_W-bit words behind a valid/ready port.
module pn_gen_param import pn_pkg::*; #(
  parameter int unsigned       LFSR_W       = 8,
  parameter int unsigned       OUT_W        = 1,
  parameter logic [LFSR_W-1:0] DEFAULT_TAPS = LFSR_W'(default_taps(LFSR_W)),
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(1)
) (
  input  logic              clk_o,
  input  logic              reset_n,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [LFSR_W-1:0] taps_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              data_PN,
  output logic              seq_start,
  output logic              lockup
);

  localparam int unsigned     CntW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(OUT_W - 1);

  pn_state_e         st_q, st_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic [LFSR_W-1:0] period_q, period_d;
  logic              seq_start_q, seq_start_d;
  logic              step;
  logic              pn_bit;
  logic              seed_hit;

  pn_lfsr_core #(
    .LFSR_W       (LFSR_W),
    .DEFAULT_TAPS (DEFAULT_TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk_o    (clk_o),
    .reset_n  (reset_n),
    .step     (step),
    .load     (load),
    .seed_in  (seed_in),
    .taps_in  (taps_in),
    .pn_bit   (pn_bit),
    .seed_hit (seed_hit),
    .lockup   (lockup)
  );

  always_comb begin
    st_d        = st_q;
    bit_cnt_d   = bit_cnt_q;
    word_d      = word_q;
    period_d    = period_q;
    seq_start_d = 1'b0;
    step        = 1'b0;
    if (load) begin
      st_d      = StFill;
      bit_cnt_d = '0;
      word_d    = '0;
      period_d  = '0;
    end else begin
      unique case (st_q)
        StFill: begin
          if (en) begin
            step        = 1'b1;
            // Shift in from the top so the first bit of the word ends up in bit 0.
            word_d      = OUT_W'({pn_bit, word_q} >> 1);
            period_d    = seed_hit ? '0 : period_q + LFSR_W'(1);
            seq_start_d = seed_hit;
            if (bit_cnt_q == LastBit) begin
              st_d      = StPresent;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
        end
        StPresent: begin
          if (out_ready) st_d = StFill;
        end
        default: st_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk_o or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= StFill;
      bit_cnt_q   <= '0;
      word_q      <= '0;
      period_q    <= '0;
      seq_start_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      bit_cnt_q   <= bit_cnt_d;
      word_q      <= word_d;
      period_q    <= period_d;
      seq_start_q <= seq_start_d;
    end
  end

  assign out_valid = (st_q == StPresent);
  assign out_data  = word_q;
  assign data_PN   = pn_bit;
  assign seq_start = seq_start_q;

endmodule

// File: tb/tb_pn_gen_param.sv
// Scoreboard bench: expected words come from a bit-stream model; a monitor pops them on handshake.
module tb_pn_gen_param;

  typedef struct packed {
    logic [15:0] word;
    logic        next_bit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       en4 = 0, load4 = 0, ready4 = 0;
  logic [3:0] seed4 = 0, taps4 = 0;
  logic       valid4, pn4, ss4, lock4;
  logic [3:0] data4;

  logic       en8 = 0, load8 = 0, ready8 = 0;
  logic [7:0] seed8 = 0, taps8 = 0;
  logic       valid8, pn8, ss8, lock8;
  logic [7:0] data8;

  pn_gen_param #(
    .LFSR_W       (4),
    .OUT_W        (4),
    .DEFAULT_TAPS (4'hC),
    .DEFAULT_SEED (4'h1)
  ) dut4 (
    .clk_o     (clk),
    .reset_n   (rst_n),
    .en        (en4),
    .load      (load4),
    .seed_in   (seed4),
    .taps_in   (taps4),
    .out_ready (ready4),
    .out_valid (valid4),
    .out_data  (data4),
    .data_PN   (pn4),
    .seq_start (ss4),
    .lockup    (lock4)
  );

  pn_gen_param #(
    .OUT_W (8)
  ) dut8 (
    .clk_o     (clk),
    .reset_n   (rst_n),
    .en        (en8),
    .load      (load8),
    .seed_in   (seed8),
    .taps_in   (taps8),
    .out_ready (ready8),
    .out_valid (valid8),
    .out_data  (data8),
    .data_PN   (pn8),
    .seq_start (ss8),
    .lockup    (lock8)
  );

  exp_t       q4[$];
  exp_t       q8[$];
  exp_t       e4, e8;
  int         checks = 0;
  int         errors = 0;
  int         ss4_cnt = 0;
  int         pops4 = 0;
  int         pops8 = 0;
  logic       first8_pending = 0;
  logic [7:0] first8 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: next register value from the feedback rule, using plain arithmetic.
  function automatic logic [31:0] model_step(logic [31:0] s, logic [31:0] t, int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((s << 1) | 32'($countones(s & t) % 2)) & mask;
  endfunction

  // Rebuild the expected word stream from a fresh load/reset point.
  task automatic gen_words(input int which, input logic [31:0] seed, input logic [31:0] taps,
                           input int n);
    int          w;
    logic [31:0] s;
    exp_t        e;
    w = (which == 0) ? 4 : 8;
    s = seed;
    if (which == 0) q4.delete();
    else q8.delete();
    for (int i = 0; i < n; i++) begin
      e.word = '0;
      for (int b = 0; b < w; b++) begin
        e.word[b] = s[0];
        s = model_step(s, taps, w);
      end
      e.next_bit = s[0];
      if (which == 0) q4.push_back(e);
      else q8.push_back(e);
    end
  endtask

  task automatic check_reset_values();
    check("rst valid4", 32'(valid4), 0);
    check("rst data4", 32'(data4), 0);
    check("rst seq4", 32'(ss4), 0);
    check("rst lock4", 32'(lock4), 0);
    check("rst pn4", 32'(pn4), 1);
    check("rst valid8", 32'(valid8), 0);
    check("rst data8", 32'(data8), 0);
    check("rst seq8", 32'(ss8), 0);
    check("rst lock8", 32'(lock8), 0);
    check("rst pn8", 32'(pn8), 1);
  endtask

  // Monitor: a word is consumed on the edge after valid & ready are seen, unless load wins.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ss4) ss4_cnt++;
      if (valid4 && ready4 && !load4) begin
        if (q4.size() == 0) begin
          bound_fail("sb4 underflow");
        end else begin
          e4 = q4.pop_front();
          check("sb4 word", 32'(data4), 32'(e4.word));
          check("sb4 pn", 32'(pn4), 32'(e4.next_bit));
          pops4++;
        end
      end
      if (valid8 && ready8 && !load8) begin
        if (q8.size() == 0) begin
          bound_fail("sb8 underflow");
        end else begin
          e8 = q8.pop_front();
          check("sb8 word", 32'(data8), 32'(e8.word));
          check("sb8 pn", 32'(pn8), 32'(e8.next_bit));
          pops8++;
          if (first8_pending) begin
            first8         = data8;
            first8_pending = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int         g;
    int         p;
    logic       chk_now, loaded_prev, lock_exp;
    logic [7:0] saved8;

    #1 rst_n = 1'b0;
    gen_words(0, 1, 32'hC, 400);
    gen_words(1, 1, 32'h9C, 200);
    #11;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    rst_n          = 1'b1;
    en4            = 1'b1;
    first8_pending = 1'b1;

    // First word appears exactly four enabled cycles after reset release.
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("latency valid4", 32'(valid4), 32'(k == 4));
    end

    // Consumer stalls: word and register must hold.
    repeat (5) begin
      @(negedge clk);
      check("stall valid4", 32'(valid4), 1);
      check("stall data4", 32'(data4), 32'(q4[0].word));
      check("stall pn4", 32'(pn4), 32'(q4[0].next_bit));
    end
    @(posedge clk);
    #1 ready4 = 1'b1;
    repeat (20) @(posedge clk);

    // Maximal-length 4-bit sequence: 60 steps hold exactly four seq_start pulses.
    #1;
    load4 = 1'b1;
    seed4 = 4'h1;
    taps4 = 4'hC;
    gen_words(0, 1, 32'hC, 400);
    @(posedge clk);
    #1;
    load4   = 1'b0;
    ss4_cnt = 0;
    pops4   = 0;
    g       = 0;
    while (pops4 < 15 && g < 200) begin
      @(posedge clk);
      #1 g++;
    end
    if (g >= 200) bound_fail("period window");
    check("seq_start count", 32'(ss4_cnt), 4);

    // All-zero seed is replaced and flagged until a nonzero seed arrives.
    load4 = 1'b1;
    seed4 = 4'h0;
    gen_words(0, 1, 32'hC, 400);
    @(posedge clk);
    #1 load4 = 1'b0;
    @(negedge clk);
    check("lockup set", 32'(lock4), 1);
    check("zero seed pn", 32'(pn4), 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("lockup sticky", 32'(lock4), 1);
    @(posedge clk);
    #1;
    load4 = 1'b1;
    seed4 = 4'h3;
    gen_words(0, 3, 32'hC, 400);
    @(posedge clk);
    #1 load4 = 1'b0;
    @(negedge clk);
    check("lockup clear", 32'(lock4), 0);

    // Load while a word is pending and ready is high: word dropped, no step.
    @(posedge clk);
    #1 ready4 = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!valid4 && g < 50);
    if (!valid4) bound_fail("pending word");
    @(posedge clk);
    #1;
    load4  = 1'b1;
    en4    = 1'b1;
    ready4 = 1'b1;
    seed4  = 4'h6;
    gen_words(0, 6, 32'hC, 400);
    @(posedge clk);
    #1 load4 = 1'b0;
    @(negedge clk);
    check("load drops valid", 32'(valid4), 0);
    check("load no step pn", 32'(pn4), 32'(seed4[0]));

    // Random enables, stalls and occasional reloads (any seed, any mask).
    chk_now     = 1'b0;
    loaded_prev = 1'b0;
    lock_exp    = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      chk_now     = loaded_prev;
      loaded_prev = 1'b0;
      load4       = 1'b0;
      en4         = ($urandom_range(0, 99) < 80);
      ready4      = en4 & 1'($urandom);
      en8         = ($urandom_range(0, 99) < 80);
      ready8      = en8 & 1'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        load4       = 1'b1;
        seed4       = 4'($urandom);
        taps4       = 4'($urandom);
        lock_exp    = (seed4 == 4'h0);
        loaded_prev = 1'b1;
        gen_words(0, (seed4 == 4'h0) ? 32'h1 : 32'(seed4), 32'(taps4), 400);
      end
      @(negedge clk);
      if (chk_now) check("random lockup", 32'(lock4), 32'(lock_exp));
    end
    check("dut8 covered 300 steps", 32'(pops8 >= 38), 1);
    saved8 = first8;

    // Asynchronous reset in the middle of a word.
    @(posedge clk);
    #1;
    load4  = 1'b0;
    en4    = 1'b1;
    ready4 = 1'b1;
    en8    = 1'b1;
    ready8 = 1'b1;
    p      = pops8;
    g      = 0;
    while (pops8 == p && g < 100) begin
      @(posedge clk);
      #1 g++;
    end
    if (g >= 100) bound_fail("dut8 word before reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_values();
    gen_words(0, 1, 32'hC, 400);
    gen_words(1, 1, 32'h9C, 200);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    first8_pending = 1'b1;
    g              = 0;
    while (first8_pending && g < 100) begin
      @(posedge clk);
      #1 g++;
    end
    if (first8_pending) bound_fail("first word after reset");
    else check("first word repeats", 32'(first8), 32'(saved8));
    repeat (60) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
